mult_hilo_ctrl: RTL and testbench

Upstream controller and result holder for the iterative 32×32 signed multiplier (`multiply`). It accepts multiply and HI/LO-move requests over a valid/ready handshake and drives the multiplier's level-held `mult_begin`. It keeps the operands stable for the whole operation and captures the 64-bit product into architectural HI/LO registers. It sits between the execute-stage issue logic and `multiply`.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/mult_ufix.sv | 31 +++
 rtl/mult_hilo_ctrl.sv | 140 ++++++++++++++
 tb/tb_mult_hilo_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the HI/LO multiply controller.
//   - request opcode encodings carried on req_op
//   - controller FSM state type
//   - operand / product widths
package mult_pkg;

    localparam int DATA_W = 32;
    localparam int PROD_W = 64;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_MTHI  = 2'b10,
        OP_MTLO  = 2'b11
    } mult_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mult_state_e;

endpackage

// File: rtl/mult_ufix.sv
// Unsigned-product correction for a signed 32x32 multiplier result.
// A signed multiply treats a set MSB as -2^31; adding the other operand
// shifted up by 32 for each such operand gives the unsigned product mod 2^64.
// Only the upper word changes, and that add wraps at 32 bits.
//
// Ports:
//   product     in  64  signed product from the multiplier
//   a, b        in  32  operands the product was formed from
//   unsigned_op in  1   apply the correction
//   result      out 64  corrected product
module mult_ufix
    import mult_pkg::*;
(
    input  logic [PROD_W-1:0] product,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              unsigned_op,
    output logic [PROD_W-1:0] result
);

    logic [DATA_W-1:0] corr;

    always_comb begin
        corr = '0;
        if (unsigned_op) begin
            corr = (a[DATA_W-1] ? b : '0) + (b[DATA_W-1] ? a : '0);
        end
        result = {product[PROD_W-1:DATA_W] + corr, product[DATA_W-1:0]};
    end

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Request controller and HI/LO holder for an iterative 32x32 multiplier.
// Accepts MULT/MULTU/MTHI/MTLO over valid/ready, holds mult_begin and the
// operands steady while the multiplier runs, and captures the product.
//
// Optional feature: define MULT_UNSIGNED_EN to give MULTU the unsigned
// correction. Without it a MULTU request is accepted and dropped.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_op, req_a, req_b opcode, operand A / move data, operand B
//   hi, lo               architectural HI/LO registers
//   mul_done             one-cycle pulse with a new product in HI/LO
//   mult_begin           level-held start to the multiplier
//   mult_op1, mult_op2   latched operands to the multiplier
//   product, mult_end    multiplier result and its (combinational) valid
//
// state | meaning
// IDLE  | ready; moves complete here
// BUSY  | multiplier running, begin and operands held
// DONE  | product in HI/LO, mul_done high, begin low for one cycle
module mult_hilo_ctrl
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              mul_done,
    output logic              mult_begin,
    output logic [DATA_W-1:0] mult_op1,
    output logic [DATA_W-1:0] mult_op2,
    input  logic [PROD_W-1:0] product,
    input  logic              mult_end
);

    mult_state_e       state, state_nxt;
    logic [DATA_W-1:0] hi_nxt, lo_nxt, op1_nxt, op2_nxt;
    logic              begin_nxt;
    logic              accept;
    logic [PROD_W-1:0] prod_fixed;

`ifdef MULT_UNSIGNED_EN
    logic mult_op_u, op_u_nxt;

    mult_ufix u_ufix (
        .product     (product),
        .a           (mult_op1),
        .b           (mult_op2),
        .unsigned_op (mult_op_u),
        .result      (prod_fixed)
    );
`else
    assign prod_fixed = product;
`endif

    assign req_ready = (state == ST_IDLE);
    assign mul_done  = (state == ST_DONE);
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_nxt = state;
        hi_nxt    = hi;
        lo_nxt    = lo;
        op1_nxt   = mult_op1;
        op2_nxt   = mult_op2;
        begin_nxt = mult_begin;
`ifdef MULT_UNSIGNED_EN
        op_u_nxt  = mult_op_u;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_MULT: begin
                            op1_nxt   = req_a;
                            op2_nxt   = req_b;
                            begin_nxt = 1'b1;
                            state_nxt = ST_BUSY;
`ifdef MULT_UNSIGNED_EN
                            op_u_nxt  = 1'b0;
`endif
                        end
                        OP_MULTU: begin
`ifdef MULT_UNSIGNED_EN
                            op1_nxt   = req_a;
                            op2_nxt   = req_b;
                            begin_nxt = 1'b1;
                            op_u_nxt  = 1'b1;
                            state_nxt = ST_BUSY;
`endif
                        end
                        OP_MTHI: hi_nxt = req_a;
                        OP_MTLO: lo_nxt = req_a;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (mult_end) begin
                    {hi_nxt, lo_nxt} = prod_fixed;
                    begin_nxt        = 1'b0;
                    state_nxt        = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hi         <= '0;
            lo         <= '0;
            mult_op1   <= '0;
            mult_op2   <= '0;
            mult_begin <= 1'b0;
`ifdef MULT_UNSIGNED_EN
            mult_op_u  <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            hi         <= hi_nxt;
            lo         <= lo_nxt;
            mult_op1   <= op1_nxt;
            mult_op2   <= op2_nxt;
            mult_begin <= begin_nxt;
`ifdef MULT_UNSIGNED_EN
            mult_op_u  <= op_u_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Bench for mult_hilo_ctrl with a behavioural model of the iterative multiplier.
// Expected products are pushed at accept time and checked by a monitor on mul_done.
module tb_mult_hilo_ctrl;
    import mult_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [31:0] hi, lo;
    logic        mul_done;
    logic        mult_begin;
    logic [31:0] mult_op1, mult_op2;
    logic [63:0] product;
    logic        mult_end;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_hilo_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .hi         (hi),
        .lo         (lo),
        .mul_done   (mul_done),
        .mult_begin (mult_begin),
        .mult_op1   (mult_op1),
        .mult_op2   (mult_op2),
        .product    (product),
        .mult_end   (mult_end)
    );

    // Multiplier model: takes ceil((p+1)/2) radix-4 steps plus one setup cycle,
    // p = top set bit of |b|; mult_end is raised while mult_begin is held.
    function automatic int mul_iters(input logic [31:0] b);
        logic [31:0] m;
        int          p;
        m = b[31] ? (~b + 32'd1) : b;
        if (m == 32'd0) return 0;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        return (p + 2) / 2;
    endfunction

    int                 mcnt = 0;
    logic signed [63:0] sa, sb;
    always @(posedge clk) mcnt <= mult_begin ? mcnt + 1 : 0;
    assign sa       = {{32{mult_op1[31]}}, mult_op1};
    assign sb       = {{32{mult_op2[31]}}, mult_op2};
    assign product  = sa * sb;
    assign mult_end = mult_begin && (mcnt == mul_iters(mult_op2) + 1);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every mul_done must match the oldest pending expectation.
    logic ready_due = 1'b0;
    always @(negedge clk) begin
        if (ready_due && !rst) chk("ready_after_done", {63'd0, req_ready}, 64'd1);
        ready_due = 1'b0;
        if (!rst && mul_done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_mul_done", {63'd0, mul_done}, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
                chk({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
                chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                chk({e.name, "_ready_low"}, {63'd0, req_ready}, 64'd0);
                ready_due = 1'b1;
            end
        end
    end

    // Returns the cyc value right after the accept edge (start of cycle 1).
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int acc);
        int t;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        t = 0;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk("accept_timeout", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic drop_valid();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Done in cycle lat => monitor sees cyc = acc + lat - 1.
    task automatic expect_mul(input logic [31:0] h, input logic [31:0] l, input int acc,
                              input int lat, input string name);
        exp_t e;
        e.hi = h; e.lo = l; e.cyc = acc + lat - 1; e.name = name;
        sbq.push_back(e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 64'(sbq.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_begin", {63'd0, mult_begin}, 64'd0);
        chk("rst_op1", {32'd0, mult_op1}, 64'd0);
        chk("rst_op2", {32'd0, mult_op2}, 64'd0);
        chk("rst_done", {63'd0, mul_done}, 64'd0);
        rst = 1'b0;

        // -3 * 7 = -21
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, acc);
        expect_mul(32'hFFFF_FFFF, 32'hFFFF_FFEB, acc, 5, "mult_neg");
        chk("busy_begin", {63'd0, mult_begin}, 64'd1);
        chk("busy_op1", {32'd0, mult_op1}, 64'hFFFF_FFFD);
        drop_valid();
        drain();

        // b = 0: fastest path
        issue(OP_MULT, 32'd5, 32'd0, acc);
        expect_mul(32'd0, 32'd0, acc, 3, "mult_zero");
        drop_valid();
        drain();

        // back-to-back moves
        issue(OP_MTHI, 32'h1234_5678, 32'd0, acc);
        chk("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        chk("mthi_ready", {63'd0, req_ready}, 64'd1);
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0, acc2);
        chk("mtlo_back_to_back", 64'(acc2 - acc), 64'd1);
        chk("mtlo_lo", {32'd0, lo}, 64'h9ABC_DEF0);
        chk("mtlo_hi_kept", {32'd0, hi}, 64'h1234_5678);
        chk("mtlo_ready", {63'd0, req_ready}, 64'd1);
        drop_valid();

`ifdef MULT_UNSIGNED_EN
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
        expect_mul(32'hFFFF_FFFE, 32'h0000_0001, acc, 4, "multu");
        drop_valid();
        drain();
`else
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
        drop_valid();
        chk("multu_off_ready", {63'd0, req_ready}, 64'd1);
        chk("multu_off_begin", {63'd0, mult_begin}, 64'd0);
        repeat (25) @(negedge clk);
        chk("multu_off_hi", {32'd0, hi}, 64'h1234_5678);
        chk("multu_off_lo", {32'd0, lo}, 64'h9ABC_DEF0);
`endif

        // MTLO held valid while the multiply is busy
        issue(OP_MULT, 32'h0001_0000, 32'h0001_0000, acc);
        expect_mul(32'h0000_0001, 32'h0000_0000, acc, 12, "mult_2e32");
        issue(OP_MTLO, 32'h0000_000A, 32'd0, acc2);
        chk("held_mtlo_accept_cycle", 64'(acc2 - acc), 64'd13);
        chk("held_mtlo_hi", {32'd0, hi}, 64'h1);
        chk("held_mtlo_lo", {32'd0, lo}, 64'hA);
        drop_valid();
        drain();

        // reset in cycle 6 of a long multiply
        issue(OP_MULT, 32'h1111_1111, 32'h4000_0000, acc);
        drop_valid();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_MTHI;
        req_a     = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        chk("abort_ready", {63'd0, req_ready}, 64'd1);
        chk("abort_begin", {63'd0, mult_begin}, 64'd0);
        repeat (25) @(negedge clk);
        chk("abort_no_late_hi", {32'd0, hi}, 64'd0);

        issue(OP_MULT, 32'd2, 32'd3, acc);
        expect_mul(32'd0, 32'd6, acc, 4, "mult_after_abort");
        drop_valid();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
